// File: rtl/time_keeper_if.sv
// Bus between time_keeper and its user: ms strobe and button levels in,
// packed BCD time word, display enable and second tick out.
interface time_keeper_if;
   logic        m_sec;
   logic        set_mode;
   logic        inc_hour;
   logic        inc_min;
   logic [13:0] time_out;
   logic        display_on;
   logic        sec_tick;

   modport master (
      output m_sec, set_mode, inc_hour, inc_min,
      input  time_out, display_on, sec_tick
   );

   modport slave (
      input  m_sec, set_mode, inc_hour, inc_min,
      output time_out, display_on, sec_tick
   );
endinterface

// File: rtl/time_keeper.sv
// 12-hour BCD time-of-day counter driven by a 1 ms strobe, with a SET mode
// in which hour/minute buttons step the time and the display blinks.
module time_keeper #(
   parameter int MS_PER_SEC  = 1000,
   parameter int SEC_PER_MIN = 60,
   parameter int BLINK_MS    = 250
)(
   input logic           clk,
   input logic           rst,
   time_keeper_if.slave  bus
);
   localparam int MS_W  = (MS_PER_SEC  > 1) ? $clog2(MS_PER_SEC)  : 1;
   localparam int SEC_W = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
   localparam int BL_W  = (BLINK_MS    > 1) ? $clog2(BLINK_MS)    : 1;

   typedef struct packed {
      logic       pm;
      logic [1:0] hr_t;
      logic [3:0] hr_o;
      logic [2:0] min_t;
      logic [3:0] min_o;
   } tk_time_t;

   typedef enum logic {RUN, SET} state_t;

   localparam tk_time_t TIME_RST = '{pm: 1'b0, hr_t: 2'd1, hr_o: 4'd2,
                                     min_t: 3'd0, min_o: 4'd0};

   // Hour sequence is 12,1..11; pm flips only on the 11 -> 12 step.
   function automatic tk_time_t hour_adv(input tk_time_t t);
      tk_time_t r;
      r = t;
      if (t.hr_t == 2'd1 && t.hr_o == 4'd1) begin
         r.hr_o = 4'd2;
         r.pm   = ~t.pm;
      end else if (t.hr_t == 2'd1 && t.hr_o == 4'd2) begin
         r.hr_t = 2'd0;
         r.hr_o = 4'd1;
      end else if (t.hr_o == 4'd9) begin
         r.hr_t = 2'd1;
         r.hr_o = 4'd0;
      end else begin
         r.hr_o = t.hr_o + 4'd1;
      end
      return r;
   endfunction

   function automatic tk_time_t min_adv(input tk_time_t t, input logic carry);
      tk_time_t r;
      r = t;
      if (t.min_o == 4'd9) begin
         r.min_o = 4'd0;
         if (t.min_t == 3'd5) begin
            r.min_t = 3'd0;
            if (carry) r = hour_adv(r);
         end else begin
            r.min_t = t.min_t + 3'd1;
         end
      end else begin
         r.min_o = t.min_o + 4'd1;
      end
      return r;
   endfunction

   state_t            state;
   tk_time_t          time_q, set_next;
   logic [MS_W-1:0]   ms_cnt;
   logic [SEC_W-1:0]  sec_cnt;
   logic [BL_W-1:0]   blink_cnt;
   logic              hour_q, min_q, display_q, tick_q;
   logic              hour_press, min_press;

   assign hour_press = bus.inc_hour & ~hour_q;
   assign min_press  = bus.inc_min  & ~min_q;

   // Both presses in one cycle touch disjoint fields, so apply both.
   always_comb begin
      set_next = time_q;
      if (min_press)  set_next = min_adv(set_next, 1'b0);
      if (hour_press) set_next = hour_adv(set_next);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         time_q    <= TIME_RST;
         ms_cnt    <= '0;
         sec_cnt   <= '0;
         blink_cnt <= '0;
         hour_q    <= 1'b0;
         min_q     <= 1'b0;
         display_q <= 1'b1;
         tick_q    <= 1'b0;
      end else begin
         hour_q <= bus.inc_hour;
         min_q  <= bus.inc_min;
         tick_q <= 1'b0;
         case (state)
            RUN: begin
               display_q <= 1'b1;
               blink_cnt <= '0;
               if (bus.m_sec) begin
                  if (ms_cnt == MS_W'(MS_PER_SEC - 1)) begin
                     ms_cnt <= '0;
                     tick_q <= 1'b1;
                     if (sec_cnt == SEC_W'(SEC_PER_MIN - 1)) begin
                        sec_cnt <= '0;
                        time_q  <= min_adv(time_q, 1'b1);
                     end else begin
                        sec_cnt <= sec_cnt + 1'b1;
                     end
                  end else begin
                     ms_cnt <= ms_cnt + 1'b1;
                  end
               end
               if (bus.set_mode) state <= SET;
            end
            SET: begin
               ms_cnt  <= '0;
               sec_cnt <= '0;
               time_q  <= set_next;
               // Leaving SET or any press shows the display and restarts the blink period.
               if (!bus.set_mode || hour_press || min_press) begin
                  display_q <= 1'b1;
                  blink_cnt <= '0;
               end else if (bus.m_sec) begin
                  if (blink_cnt == BL_W'(BLINK_MS - 1)) begin
                     blink_cnt <= '0;
                     display_q <= ~display_q;
                  end else begin
                     blink_cnt <= blink_cnt + 1'b1;
                  end
               end
               if (!bus.set_mode) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   assign bus.time_out   = time_q;
   assign bus.display_on = display_q;
   assign bus.sec_tick   = tick_q;
endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with shortened timing parameters:
// a vector table for reset/run/set basics, then hand sequences for corners.
module tb_time_keeper;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   time_keeper_if bus();

   time_keeper #(.MS_PER_SEC(4), .SEC_PER_MIN(3), .BLINK_MS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r, ms, sm, ih, im;
      logic [13:0] t;
      logic        d, k;
   } vec_t;

   vec_t tbl[22];

   function automatic logic [13:0] bcd(input int h, input int m, input logic pm);
      return {pm, 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic ms, input logic sm,
                      input logic ih, input logic im);
      rst = r; bus.m_sec = ms; bus.set_mode = sm; bus.inc_hour = ih; bus.inc_min = im;
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic sm, output logic tk);
      cyc(1'b0, 1'b1, sm, 1'b0, 1'b0);
      tk = bus.sec_tick;
      cyc(1'b0, 1'b0, sm, 1'b0, 1'b0);
   endtask

   task automatic run_strobes(input int n, output int ticks);
      logic tk;
      ticks = 0;
      for (int i = 0; i < n; i++) begin
         strobe(1'b0, tk);
         ticks += int'(tk);
      end
   endtask

   // Reset, enter SET, then step hours/minutes by single presses.
   task automatic preset(input int hp, input int mp);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < hp; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      for (int i = 0; i < mp; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
   endtask

   initial begin
      int   ticks;
      logic tk;
      logic [2:0] early;
      bus.m_sec = 1'b0; bus.set_mode = 1'b0; bus.inc_hour = 1'b0; bus.inc_min = 1'b0;

      //          r     ms    sm    ih    im      time    disp  tick
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0900, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0900, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0900, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0900, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0900, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0900, 1'b1, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0900, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0900, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0900, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0900, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0900, 1'b1, 1'b1};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0900, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0900, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0900, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0901, 1'b1, 1'b1};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0901, 1'b1, 1'b0};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0901, 1'b1, 1'b0};
      tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 14'h0902, 1'b1, 1'b0};
      tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 14'h0902, 1'b1, 1'b0};
      tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0902, 1'b1, 1'b0};
      tbl[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 14'h0082, 1'b1, 1'b0};
      tbl[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0082, 1'b1, 1'b0};

      for (int i = 0; i < 22; i++) begin
         cyc(tbl[i].r, tbl[i].ms, tbl[i].sm, tbl[i].ih, tbl[i].im);
         chk($sformatf("vec%0d", i), {16'h0, bus.time_out, bus.display_on, bus.sec_tick},
             {16'h0, tbl[i].t, tbl[i].d, tbl[i].k});
      end

      // 36 strobes from reset: three minutes, nine second ticks.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_strobes(36, ticks);
      chk("run36_time", 32'(bus.time_out), 32'(bcd(12, 3, 1'b0)));
      chk("run36_ticks", 32'(ticks), 32'd9);

      // Held inc_min yields a single step.
      preset(0, 0);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("hold_min", 32'(bus.time_out), 32'(bcd(12, 1, 1'b0)));

      // Minute wrap in SET does not carry into hours.
      preset(0, 59);
      chk("preset_1259", 32'(bus.time_out), 32'(bcd(12, 59, 1'b0)));
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("set_min_wrap", 32'(bus.time_out), 32'(bcd(12, 0, 1'b0)));

      // Both buttons in one cycle.
      preset(11, 30);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("both_press", 32'(bus.time_out), 32'(bcd(12, 31, 1'b1)));

      // 11:59 AM -> 12:00 PM via RUN carry.
      preset(11, 59);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_strobes(12, ticks);
      chk("carry_noon", 32'(bus.time_out), 32'(bcd(12, 0, 1'b1)));
      chk("carry_noon_pm", 32'(bus.time_out[13]), 32'd1);
      chk("carry_noon_ticks", 32'(ticks), 32'd3);

      // 12:59 PM -> 1:00 PM, pm unchanged.
      preset(12, 59);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_strobes(12, ticks);
      chk("carry_1pm", 32'(bus.time_out), 32'(bcd(1, 0, 1'b1)));

      // Blink: toggle every 2 strobes; press mid-off restarts the period.
      preset(0, 0);
      strobe(1'b1, tk); chk("blink_s1", 32'(bus.display_on), 32'd1);
      strobe(1'b1, tk); chk("blink_s2", 32'(bus.display_on), 32'd0);
      strobe(1'b1, tk);
      strobe(1'b1, tk); chk("blink_s4", 32'(bus.display_on), 32'd1);
      strobe(1'b1, tk);
      strobe(1'b1, tk);
      strobe(1'b1, tk); chk("blink_s7", 32'(bus.display_on), 32'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("blink_press", 32'(bus.display_on), 32'd1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      strobe(1'b1, tk); chk("blink_restart1", 32'(bus.display_on), 32'd1);
      strobe(1'b1, tk); chk("blink_restart2", 32'(bus.display_on), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("exit_disp", 32'(bus.display_on), 32'd1);
      early = '0;
      for (int i = 0; i < 3; i++) begin
         strobe(1'b0, tk);
         early[i] = tk;
      end
      chk("resume_no_early_tick", 32'(early), 32'd0);
      strobe(1'b0, tk);
      chk("resume_tick4", 32'(tk), 32'd1);

      // Reset in SET at 7:45 PM with the display blanked; m_sec during rst ignored.
      preset(19, 45);
      chk("preset_745pm", 32'(bus.time_out), 32'(bcd(7, 45, 1'b1)));
      strobe(1'b1, tk);
      strobe(1'b1, tk);
      chk("pre_rst_blank", 32'(bus.display_on), 32'd0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("mid_rst", {16'h0, bus.time_out, bus.display_on, bus.sec_tick},
          {16'h0, 14'h0900, 1'b1, 1'b0});
      early = '0;
      for (int i = 0; i < 3; i++) begin
         strobe(1'b0, tk);
         early[i] = tk;
      end
      chk("post_rst_no_early_tick", 32'(early), 32'd0);
      strobe(1'b0, tk);
      chk("post_rst_tick4", 32'(tk), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
